// File: rtl/mem_xfer_pkg.sv
// Shared constants and phase decode for the memory-transfer core.
package mem_xfer_pkg;

  localparam int DATA_W  = 8;
  localparam int A_DEPTH = 8;
  localparam int B_DEPTH = 4;
  localparam int CNT_W   = 5;
  localparam int ADDR_W  = $clog2(A_DEPTH);

  // Write phase fills A; read phase spends two steps per memory B entry.
  localparam logic [CNT_W-1:0] WR_END   = CNT_W'(A_DEPTH - 1);
  localparam logic [CNT_W-1:0] RD_END   = CNT_W'(A_DEPTH - 1 + 2 * B_DEPTH);
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(A_DEPTH + 2 * B_DEPTH);

  typedef enum logic [1:0] {
    PH_WRITE,
    PH_READ,
    PH_DONE
  } phase_t;

  function automatic phase_t phase_of(input logic [CNT_W-1:0] cnt);
    if (cnt <= WR_END)      return PH_WRITE;
    else if (cnt <= RD_END) return PH_READ;
    else                    return PH_DONE;
  endfunction

endpackage

// File: rtl/mem_xfer_ctrl.sv
// Step counter and strobe decode for the memory-transfer sequence.
// Optional done output with MEM_XFER_DONE_EN.
//   state    | meaning
//   PH_WRITE | counter 0..7, write memory A and advance AddrA
//   PH_READ  | counter 8..15, read pairs; odd steps strobe memory B
//   PH_DONE  | counter 16, idle until reset
module mem_xfer_ctrl
  import mem_xfer_pkg::*;
(
  input  logic             clock,
  input  logic             Reset,
  output logic [CNT_W-1:0] counter,
  output logic             wea,
  output logic             inca,
  output logic             web,
  output logic             incb
`ifdef MEM_XFER_DONE_EN
  ,
  output logic             done
`endif
);

  phase_t phase;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset)
      counter <= '0;
    else if (counter != DONE_CNT)
      counter <= counter + 1'b1;
  end

  assign phase = phase_of(counter);

  // Strobes are decoded from the step directly so step 0 already writes;
  // Reset gates them so no write lands while reset is held.
  always_comb begin
    wea  = 1'b0;
    inca = 1'b0;
    web  = 1'b0;
    incb = 1'b0;
    if (!Reset) begin
      case (phase)
        PH_WRITE: begin
          wea  = 1'b1;
          inca = 1'b1;
        end
        PH_READ: begin
          inca = 1'b1;
          web  = counter[0];
          incb = counter[0];
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_XFER_DONE_EN
  assign done = !Reset && (phase == PH_DONE);
`endif

endmodule

// File: rtl/mem_transfer_core.sv
// Memory A, its address counter and the pair add/sub combiner feeding memory B.
// Optional done output with MEM_XFER_DONE_EN.
module mem_transfer_core
  import mem_xfer_pkg::*;
(
  input  logic              clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] DataInA,
  output logic              WEA,
  output logic              IncA,
  output logic              WEB,
  output logic              IncB,
  output logic [ADDR_W-1:0] AddrA,
  output logic [DATA_W-1:0] Dout1,
  output logic [DATA_W-1:0] Dout2,
  output logic [DATA_W-1:0] ADDOut,
  output logic [DATA_W-1:0] SUBOut,
  output logic [DATA_W-1:0] DataInB,
  output logic [CNT_W-1:0]  counter
`ifdef MEM_XFER_DONE_EN
  ,
  output logic              done
`endif
);

  logic [DATA_W-1:0] mem_a [A_DEPTH];

  mem_xfer_ctrl u_ctrl (
    .clock   (clock),
    .Reset   (Reset),
    .counter (counter),
    .wea     (WEA),
    .inca    (IncA),
    .web     (WEB),
    .incb    (IncB)
`ifdef MEM_XFER_DONE_EN
    ,
    .done    (done)
`endif
  );

  // No reset on the array: contents survive a mid-sequence reset.
  always_ff @(posedge clock) begin
    if (WEA)
      mem_a[AddrA] <= DataInA;
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset)
      AddrA <= '0;
    else if (IncA)
      AddrA <= AddrA + 1'b1;
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset)
      Dout2 <= '0;
    else
      Dout2 <= Dout1;
  end

  assign Dout1   = mem_a[AddrA];
  assign ADDOut  = Dout1 + Dout2;
  assign SUBOut  = Dout1 - Dout2;
  assign DataInB = (Dout1 > Dout2) ? SUBOut : ADDOut;

endmodule

// File: tb/tb_mem_transfer_core.sv
// Directed table-driven bench for mem_transfer_core; done checked with MEM_XFER_DONE_EN.
module tb_mem_transfer_core;

  typedef struct packed {
    logic [7:0][7:0] din;
    logic [3:0][7:0] expb;
  } vec_t;

  logic       clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] DataInA = 8'd0;
  logic       WEA, IncA, WEB, IncB;
  logic [2:0] AddrA;
  logic [7:0] Dout1, Dout2, ADDOut, SUBOut, DataInB;
  logic [4:0] counter;
`ifdef MEM_XFER_DONE_EN
  logic       done;
`endif

  vec_t vecs [4];
  int   n_assert = 0;
  int   n_fail   = 0;

  mem_transfer_core dut (
    .clock   (clock),
    .Reset   (Reset),
    .DataInA (DataInA),
    .WEA     (WEA),
    .IncA    (IncA),
    .WEB     (WEB),
    .IncB    (IncB),
    .AddrA   (AddrA),
    .Dout1   (Dout1),
    .Dout2   (Dout2),
    .ADDOut  (ADDOut),
    .SUBOut  (SUBOut),
    .DataInB (DataInB),
    .counter (counter)
`ifdef MEM_XFER_DONE_EN
    ,
    .done    (done)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(input int mem0);
    chk("rst counter", counter, 0);
    chk("rst AddrA", AddrA, 0);
    chk("rst Dout2", Dout2, 0);
    chk("rst WEA", WEA, 0);
    chk("rst IncA", IncA, 0);
    chk("rst WEB", WEB, 0);
    chk("rst IncB", IncB, 0);
    if (mem0 >= 0) chk("rst Dout1", Dout1, mem0);
`ifdef MEM_XFER_DONE_EN
    chk("rst done", done, 0);
`endif
  endtask

  // Entered at posedge+1 right after reset release; ends at the negedge of last_c.
  task automatic run_seq(input int idx, input int last_c);
    vec_t v;
    int   cs, k, d1, d2;
    v = vecs[idx];
    for (int c = 0; c <= last_c; c++) begin
      DataInA = (c < 8) ? v.din[c] : 8'd0;
      @(negedge clock);
      cs = (c > 16) ? 16 : c;
      chk($sformatf("v%0d c%0d counter", idx, c), counter, cs);
      chk($sformatf("v%0d c%0d WEA", idx, c), WEA, int'(cs <= 7));
      chk($sformatf("v%0d c%0d IncA", idx, c), IncA, int'(cs <= 15));
      chk($sformatf("v%0d c%0d WEB", idx, c), WEB, int'(cs >= 8 && cs <= 15 && cs % 2 == 1));
      chk($sformatf("v%0d c%0d IncB", idx, c), IncB, int'(cs >= 8 && cs <= 15 && cs % 2 == 1));
      chk($sformatf("v%0d c%0d AddrA", idx, c), AddrA, (cs < 16) ? cs % 8 : 0);
      if (cs >= 8 && cs <= 15)
        chk($sformatf("v%0d c%0d Dout1", idx, c), Dout1, int'(v.din[cs-8]));
      if (cs >= 9 && cs <= 15)
        chk($sformatf("v%0d c%0d Dout2", idx, c), Dout2, int'(v.din[cs-9]));
      if (cs >= 9 && cs <= 15 && cs % 2 == 1) begin
        k  = (cs - 9) / 2;
        d1 = v.din[2*k+1];
        d2 = v.din[2*k];
        chk($sformatf("v%0d c%0d ADDOut", idx, c), ADDOut, (d1 + d2) % 256);
        chk($sformatf("v%0d c%0d SUBOut", idx, c), SUBOut, (d1 - d2 + 256) % 256);
        chk($sformatf("v%0d c%0d DataInB", idx, c), DataInB, int'(v.expb[k]));
      end
`ifdef MEM_XFER_DONE_EN
      chk($sformatf("v%0d c%0d done", idx, c), done, int'(cs == 16));
`endif
      if (c != last_c) begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  initial begin
    // din[0] is the word written at counter 0 (rightmost element).
    vecs[0].din  = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    vecs[0].expb = {8'd1, 8'd1, 8'd1, 8'd1};
    vecs[1].din  = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    vecs[1].expb = {8'd3, 8'd7, 8'd11, 8'd15};
    vecs[2].din  = {8'd0, 8'd0, 8'd250, 8'd10, 8'd5, 8'd5, 8'd100, 8'd200};
    vecs[2].expb = {8'd0, 8'd240, 8'd10, 8'd44};
    vecs[3].din  = {8'd128, 8'd128, 8'd0, 8'd1, 8'd255, 8'd0, 8'd255, 8'd255};
    vecs[3].expb = {8'd0, 8'd1, 8'd255, 8'd254};

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset(-1);

    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        Reset = 1'b1;
        #1;
        chk_reset(int'(vecs[i-1].din[0]));
      end
      @(posedge clock);
      #1;
      Reset = 1'b0;
      run_seq(i, (i == 0) ? 40 : 16);
    end

    // Reset in the middle of the read phase, then restart over retained memory.
    Reset = 1'b1;
    @(posedge clock);
    #1;
    Reset = 1'b0;
    run_seq(0, 12);
    Reset = 1'b1;
    #1;
    chk_reset(int'(vecs[0].din[0]));
    DataInA = 8'h77;
    repeat (2) @(posedge clock);
    #1;
    chk("held rst write blocked", Dout1, int'(vecs[0].din[0]));
    chk("held rst counter", counter, 0);
    Reset = 1'b0;
    chk("release mem retained", Dout1, int'(vecs[0].din[0]));
    run_seq(1, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
